// File: rtl/reg_file_8x16.sv
// rtl/reg_file_8x16.sv - 8-entry register file, one write port, two registered read ports
// Read ports forward same-cycle write data; write counter saturates at 255.
module reg_file_8x16 #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 3
) (
    input  logic              CLK,
    input  logic              Reset_n,
    input  logic              WrEn,
    input  logic [ADDR_W-1:0] WrAddr,
    input  logic [DATA_W-1:0] WrData,
    input  logic              RdEnA,
    input  logic [ADDR_W-1:0] RdAddrA,
    input  logic              RdEnB,
    input  logic [ADDR_W-1:0] RdAddrB,
    output logic [DATA_W-1:0] RdDataA,
    output logic [DATA_W-1:0] RdDataB,
    output logic              RdValidA,
    output logic              RdValidB,
    output logic [7:0]        WrCount
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_rd_data_a;
    logic [DATA_W-1:0] r_rd_data_b;
    logic              r_rd_valid_a;
    logic              r_rd_valid_b;
    logic [7:0]        r_wr_count;

    logic [DATA_W-1:0] w_rd_a;
    logic [DATA_W-1:0] w_rd_b;

    // Same-cycle write to the read address wins over the stored value.
    always_comb begin
        w_rd_a = r_mem[RdAddrA];
        w_rd_b = r_mem[RdAddrB];
        if (WrEn && (WrAddr == RdAddrA)) begin
            w_rd_a = WrData;
        end
        if (WrEn && (WrAddr == RdAddrB)) begin
            w_rd_b = WrData;
        end
    end

    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (WrEn) begin
            r_mem[WrAddr] <= WrData;
        end
    end

    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            r_rd_data_a  <= '0;
            r_rd_data_b  <= '0;
            r_rd_valid_a <= 1'b0;
            r_rd_valid_b <= 1'b0;
            r_wr_count   <= '0;
        end else begin
            r_rd_valid_a <= RdEnA;
            r_rd_valid_b <= RdEnB;
            if (RdEnA) begin
                r_rd_data_a <= w_rd_a;
            end
            if (RdEnB) begin
                r_rd_data_b <= w_rd_b;
            end
            if (WrEn && (r_wr_count != 8'hFF)) begin
                r_wr_count <= r_wr_count + 8'd1;
            end
        end
    end

    assign RdDataA  = r_rd_data_a;
    assign RdDataB  = r_rd_data_b;
    assign RdValidA = r_rd_valid_a;
    assign RdValidB = r_rd_valid_b;
    assign WrCount  = r_wr_count;

endmodule
